// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Optional macro MEM_ARB_RR_EN: round-robin on simultaneous requests (default: data has priority).
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              grant,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pick_d;

    // Winner selection; grant doubles as the last-owner pointer.
`ifdef MEM_ARB_RR_EN
    assign pick_d = d_req & (~if_req | ~grant);
`else
    assign pick_d = d_req;
`endif

    // Request/response sequencing with watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        grant     <= pick_d;
                        mem_we    <= pick_d & d_we;
                        mem_addr  <= pick_d ? d_addr : if_addr;
                        mem_wdata <= pick_d ? d_wdata : '0;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        err     <= 1'b0;
                        if (grant) begin
                            d_ack <= 1'b1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        if (grant) begin
                            d_ack <= 1'b1;
                            if (!mem_we) d_rdata <= '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= '0;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (default fixed-priority build).
// Stimulus pushes expected memory and ack transactions; monitors pop and compare.
module tb_mem_port_arbiter;

    localparam int TO = 15;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        if_req = 0;
    logic [15:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 0;
    logic        d_we = 0;
    logic [15:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 0;
    logic        grant;
    logic        busy;
    logic        err;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .grant(grant), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } aexp_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    aexp_t aq[$];
    mexp_t mq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int          ack_delay = -1;
    logic [31:0] rd_base = '0;
    bit          stray = 0;
    int          wcnt = 0;
    bit          done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: acks ack_delay cycles into BUSY; negative delay never acks.
    always @(negedge clk) begin
        if (!mem_req) begin
            wcnt = 0;
            done = 0;
            mem_ack = stray;
            mem_rdata = stray ? 32'hFFFF_FFFF : 32'h0;
        end else begin
            mem_ack = 0;
            if (!done && ack_delay >= 0 && wcnt == ack_delay) begin
                mem_ack = 1;
                mem_rdata = rd_base ^ {16'h0, mem_addr};
                done = 1;
            end
            wcnt++;
        end
    end

    // Monitor: checks memory bus on each access and each ack against the scoreboard.
    logic  mreq_q = 0;
    int    rise_cyc = 0;
    mexp_t cur_m;
    always @(negedge clk) begin
        if (!rst_n) begin
            mreq_q = 0;
        end else begin
            if (mem_req && !mreq_q) begin
                rise_cyc = cyc;
                if (mq.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    cur_m = mq.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, cur_m.we});
                    chk("mem_addr", {16'd0, mem_addr}, {16'd0, cur_m.addr});
                    chk("mem_wdata", mem_wdata, cur_m.wdata);
                end
            end else if (mem_req) begin
                chk("mem_addr_stable", {16'd0, mem_addr}, {16'd0, cur_m.addr});
                chk("mem_we_stable", {31'd0, mem_we}, {31'd0, cur_m.we});
            end
            mreq_q = mem_req;
            if (if_ack || d_ack) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", {30'd0, if_ack, d_ack}, 32'd0);
                end else begin
                    aexp_t e;
                    e = aq.pop_front();
                    chk("ack_port", {30'd0, if_ack, d_ack}, e.port ? 32'd1 : 32'd2);
                    chk("ack_rdata", e.port ? d_rdata : if_rdata, e.rdata);
                    chk("ack_err", {31'd0, err}, {31'd0, e.err});
                    chk("ack_latency", cyc - rise_cyc, e.lat);
                    chk("grant", {31'd0, grant}, {31'd0, e.port});
                    chk("busy_resp", {31'd0, busy}, 32'd1);
                end
                if (if_ack) if_req = 0;
                if (d_ack) begin
                    d_req = 0;
                    d_we = 0;
                end
            end
        end
    end

    task automatic exp_acc(input bit port, input bit we, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input bit e, input int lat);
        mexp_t m;
        aexp_t a;
        m.we = we; m.addr = addr; m.wdata = wdata;
        a.port = port; a.rdata = rdata; a.err = e; a.lat = lat;
        mq.push_back(m);
        aq.push_back(a);
    endtask

    task automatic drive_if(input logic [15:0] a);
        if_addr = a;
        if_req = 1;
    endtask

    task automatic drive_d(input bit we, input logic [15:0] a, input logic [31:0] wd);
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        d_req = 1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!if_req && !d_req && aq.size() == 0) ok = 1;
        end
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_grant_err", {30'd0, grant, err}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // IF read, ack two cycles into BUSY
        ack_delay = 2;
        rd_base = 32'h2001_0001;
        exp_acc(0, 0, 16'h0004, 32'h0, 32'h2001_0005, 0, 3);
        drive_if(16'h0004);
        wait_done("if_read", 40);

        // Data load to give d_rdata a known value
        ack_delay = 0;
        rd_base = 32'h1234_0000;
        exp_acc(1, 0, 16'h0200, 32'h0, 32'h1234_0200, 0, 1);
        drive_d(0, 16'h0200, 32'h0);
        wait_done("d_load", 40);

        // Store: d_rdata must keep the loaded value
        ack_delay = 1;
        rd_base = 32'hBAD0_0000;
        exp_acc(1, 1, 16'h0100, 32'hDEAD_BEEF, 32'h1234_0200, 0, 2);
        drive_d(1, 16'h0100, 32'hDEAD_BEEF);
        wait_done("store", 40);
        chk("if_rdata_hold", if_rdata, 32'h2001_0005);

        // Contention twice: data then IF each time
        ack_delay = 1;
        rd_base = 32'h5555_0000;
        exp_acc(1, 0, 16'h0300, 32'h0, 32'h5555_0300, 0, 2);
        exp_acc(0, 0, 16'h0008, 32'h0, 32'h5555_0008, 0, 2);
        drive_if(16'h0008);
        drive_d(0, 16'h0300, 32'h0);
        wait_done("contend1", 60);
        exp_acc(1, 0, 16'h0310, 32'h0, 32'h5555_0310, 0, 2);
        exp_acc(0, 0, 16'h000C, 32'h0, 32'h5555_000C, 0, 2);
        drive_if(16'h000C);
        drive_d(0, 16'h0310, 32'h0);
        wait_done("contend2", 60);

        // Timeout on a load
        ack_delay = -1;
        exp_acc(1, 0, 16'h0400, 32'h0, 32'h0, 1, TO + 1);
        drive_d(0, 16'h0400, 32'h0);
        wait_done("timeout", 60);
        chk("err_cleared", {31'd0, err}, 32'd0);

        // mem_ack in the last permitted BUSY cycle wins over timeout
        ack_delay = TO;
        rd_base = 32'h7777_0000;
        exp_acc(1, 0, 16'h0500, 32'h0, 32'h7777_0500, 0, TO + 1);
        drive_d(0, 16'h0500, 32'h0);
        wait_done("ack_at_timeout", 60);

        // Stray mem_ack while idle
        stray = 1;
        @(negedge clk);
        stray = 0;
        repeat (3) @(negedge clk);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
        chk("stray_d_rdata", d_rdata, 32'h7777_0500);

        // Reset in the middle of BUSY
        ack_delay = -1;
        begin
            mexp_t m;
            m.we = 0; m.addr = 16'h0010; m.wdata = 32'h0;
            mq.push_back(m);
        end
        drive_if(16'h0010);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("mid_rst_if_rdata", if_rdata, 32'd0);
        if_req = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (TO + 6) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("aq_empty", aq.size(), 32'd0);
        chk("mq_empty", mq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
